ctrl_credit_selector: RTL and testbench
=======================================

// Module: ctrl_credit_selector
// PURPOSE
// - Credit-gated, round-robin selector sequencer for a shared EP2 datapath.
// - Counts pending events per source and grants one source at a time, round-robin.
// - Broadcasts the granted index to REPLICATED_OUT_NUM consumers; each replica handshakes independently.
// - Caps outstanding grants with a credit pool refilled by the downstream completion pulse.
// PARAMETERS
// - S_COUNT             2                  number of requesting sources
// - SELECT_WIDTH        $clog2(S_COUNT)    width of selector index
// - REPLICATED_OUT_NUM  3                  number of selector consumers
// - CNT_WIDTH           8                  per-source pending counter width (max 2^CNT_WIDTH-1)
// - CREDIT_INIT         4                  credits after reset = max outstanding grants (>=1)
// PORTS
// - clk                   in   1                           clock, all logic rising-edge
// - rst                   in   1                           synchronous, active-high reset
// - s_inc_tdata           in   S_COUNT                     per-source event pulse
// - s_inc_tready          out  S_COUNT                     per-source accept; low while counter at max
// - m_selector_tdata      out  REPLICATED_OUT_NUM*SELECT_WIDTH   granted index, replicated per consumer
// - m_selector_tvalid     out  REPLICATED_OUT_NUM          per-consumer valid
// - m_selector_tready     in   REPLICATED_OUT_NUM          per-consumer ready
// - credit_return         in   1                           one grant completed downstream; +1 credit
// - err_credit_ovf        out  1                           sticky: credit_return seen with pool full
// BEHAVIOUR
// - Reset: counters=0, credits=CREDIT_INIT, tvalid=0, tdata=0, err=0, state=IDLE, rr_last=S_COUNT-1.
// - Reset mid-broadcast: tvalid drops on the next cycle; the in-flight grant is discarded and not re-issued.
// - Accept rule: event i accepted iff s_inc_tdata[i] & s_inc_tready[i].
// - s_inc_tready[i] = (cnt[i] != max), combinational from the registered count. A pending same-cycle decrement does NOT raise tready.
// - Counter update: accept & !grant_i -> +1; grant_i & !accept -> -1; both -> unchanged.
// - Never wraps; events offered while tready is low are dropped by the source contract.
// - Latch condition `can_latch`: credits>0, some cnt>0, and state==IDLE or the broadcast is completing this cycle.
// - Winner: first source with cnt>0 scanning rr_last+1 .. wrapping.
// - On latch: sel_q<=winner, pend<=all ones, rr_last<=winner, cnt[winner]-1, credits-1, state<=BCAST.
// - BCAST: m_selector_tvalid[r]=pend[r]; every tdata slice = sel_q, held stable.
// - BCAST: pend[r] clears on tvalid[r]&tready[r]; replicas may accept in any order and any cycles.
// - Completion cycle: (pend & ~(tvalid&tready))==0.
// - Completion: state<=IDLE, or back-to-back re-latch with no bubble if can_latch holds.
// - Latency: event accepted at cycle N with idle state and credit available -> tvalid high at N+2.
// - Credits: latch & !credit_return -> -1; credit_return & !latch -> +1; both -> unchanged.
// - credit_return with credits==CREDIT_INIT and no latch -> ignored, err_credit_ovf<=1 until rst.
// - Credits==0: no new latch; the current broadcast still completes; counts keep accumulating.
// - S_COUNT==1: RR degenerates, always selects 0.
// STRUCTURE
// - Package ep2_ctrl_pkg: state enum {IDLE,BCAST}, sel_t/cnt_t/credit_t typedefs, clog2 helper consts.
// - Sub-module ctrl_rr_pick: combinational.
//   - Inputs: req[S_COUNT], rr_last.
//   - Outputs: found, winner index.
// - Top holds counters, credit pool, pend mask, FSM.
// TESTING
// - Single event src1, all tready=1, CREDIT_INIT=4:
//   - tvalid=3'b111 at N+2, tdata=1 on each slice, one cycle.
//   - cnt[1] back to 0; credits=3.
// - Events on src0 and src1 same cycle, tready=1:
//   - grants 0 then 1 on consecutive cycles (no bubble).
//   - next pair of events -> 0 then 1 again (RR fairness).
// - Staggered tready (r0 at +0, r2 at +3, r1 at +5):
//   - tdata stable throughout; pend clears per replica.
//   - next grant only after r1 accepts.
// - 6 events on src0, CREDIT_INIT=4, no credit_return:
//   - exactly 4 grants, cnt[0]=2 held.
//   - one credit_return -> one more grant.
// - 255 events on src0 with tready=0 on outputs:
//   - s_inc_tready[0] low at cnt=255.
//   - one grant then re-high.
// - credit_return with pool full -> err_credit_ovf=1, credits stay 4.
// - rst mid-BCAST -> tvalid=0 next cycle, all counters 0.

Source files
------------

// File: rtl/ep2_ctrl_pkg.sv
// Shared types and sizing helpers for the EP2 credit-gated selector.
package ep2_ctrl_pkg;

  typedef enum logic {IDLE = 1'b0, BCAST = 1'b1} state_e;

  // Width of an index/count field; never collapses to zero bits.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_S_COUNT     = 2;
  localparam int DEF_CNT_WIDTH   = 8;
  localparam int DEF_CREDIT_INIT = 4;
  localparam int DEF_SEL_W       = clog2_min1(DEF_S_COUNT);
  localparam int DEF_CRED_W      = clog2_min1(DEF_CREDIT_INIT + 1);

  typedef logic [DEF_SEL_W-1:0]     sel_t;
  typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;
  typedef logic [DEF_CRED_W-1:0]    credit_t;

endpackage

// File: rtl/ctrl_rr_pick.sv
// Round-robin picker: first requester after rr_last_i, wrapping.
module ctrl_rr_pick #(
  parameter int S_COUNT = 2,
  parameter int SEL_W   = 1
) (
  input  logic [S_COUNT-1:0] req_i,
  input  logic [SEL_W-1:0]   rr_last_i,
  output logic               found_o,
  output logic [SEL_W-1:0]   winner_o
);

  // Scan rr_last+1 .. rr_last+S_COUNT modulo S_COUNT; the first hit wins.
  always_comb begin
    logic             hit;
    logic [SEL_W-1:0] ii;
    int unsigned      idx;
    hit      = 1'b0;
    ii       = '0;
    idx      = 0;
    winner_o = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      idx = (int'(rr_last_i) + k) % S_COUNT;
      ii  = SEL_W'(idx);
      if (!hit && req_i[ii]) begin
        hit      = 1'b1;
        winner_o = ii;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/ctrl_credit_selector.sv
// Credit-gated round-robin selector; broadcasts each grant to all consumers.
module ctrl_credit_selector
  import ep2_ctrl_pkg::*;
#(
  parameter int S_COUNT            = 2,
  parameter int SELECT_WIDTH       = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int REPLICATED_OUT_NUM = 3,
  parameter int CNT_WIDTH          = 8,
  parameter int CREDIT_INIT        = 4
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [S_COUNT-1:0]                         s_inc_tdata,
  output logic [S_COUNT-1:0]                         s_inc_tready,
  output logic [REPLICATED_OUT_NUM*SELECT_WIDTH-1:0] m_selector_tdata,
  output logic [REPLICATED_OUT_NUM-1:0]              m_selector_tvalid,
  input  logic [REPLICATED_OUT_NUM-1:0]              m_selector_tready,
  input  logic                                       credit_return,
  output logic                                       err_credit_ovf
);

  localparam int CW = clog2_min1(CREDIT_INIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CW-1:0]        CRED_MAX = CW'(CREDIT_INIT);

  state_e                              state_q, state_d;
  logic [S_COUNT-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]                       credits_q, credits_d;
  logic [SELECT_WIDTH-1:0]             sel_q, sel_d, rr_last_q, rr_last_d;
  logic [REPLICATED_OUT_NUM-1:0]       pend_q, pend_d;
  logic                                err_q, err_d;

  logic [S_COUNT-1:0]                  accept, req;
  logic [REPLICATED_OUT_NUM-1:0]       hs;
  logic                                found, completing, can_latch;
  logic [SELECT_WIDTH-1:0]             winner;

  // Per-source accept and non-empty request vectors from registered counts.
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      s_inc_tready[i] = (cnt_q[i] != CNT_MAX);
      req[i]          = (cnt_q[i] != '0);
    end
    accept = s_inc_tdata & s_inc_tready;
  end

  ctrl_rr_pick #(.S_COUNT(S_COUNT), .SEL_W(SELECT_WIDTH)) u_pick (
    .req_i     (req),
    .rr_last_i (rr_last_q),
    .found_o   (found),
    .winner_o  (winner)
  );

  // A new grant may latch from IDLE or in the cycle the last replica accepts.
  always_comb begin
    hs         = m_selector_tvalid & m_selector_tready;
    completing = (state_q == BCAST) && ((pend_q & ~hs) == '0);
    can_latch  = (credits_q != '0) && found && ((state_q == IDLE) || completing);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: broadcast persists until every replica has handshaked.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (can_latch) state_d = BCAST;
      BCAST:   if (completing) state_d = can_latch ? BCAST : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pend mask drives per-replica valid; every slice carries sel_q.
  always_comb begin
    m_selector_tvalid = (state_q == BCAST) ? pend_q : '0;
    for (int r = 0; r < REPLICATED_OUT_NUM; r++)
      m_selector_tdata[r*SELECT_WIDTH +: SELECT_WIDTH] = sel_q;
    err_credit_ovf = err_q;
  end

  // Datapath next-state: counters, credit pool, grant latch, pend mask.
  always_comb begin
    cnt_d     = cnt_q;
    credits_d = credits_q;
    sel_d     = sel_q;
    rr_last_d = rr_last_q;
    err_d     = err_q;
    pend_d    = (state_q == BCAST) ? (pend_q & ~hs) : '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (accept[i] && !(can_latch && winner == SELECT_WIDTH'(i)))
        cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!accept[i] && can_latch && winner == SELECT_WIDTH'(i))
        cnt_d[i] = cnt_q[i] - 1'b1;
    end
    if (can_latch) begin
      sel_d     = winner;
      rr_last_d = winner;
      pend_d    = '1;
    end
    if (can_latch && !credit_return) begin
      credits_d = credits_q - 1'b1;
    end else if (credit_return && !can_latch) begin
      if (credits_q == CRED_MAX) err_d = 1'b1;
      else                       credits_d = credits_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      credits_q <= CRED_MAX;
      sel_q     <= '0;
      rr_last_q <= SELECT_WIDTH'(S_COUNT - 1);
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
      sel_q     <= sel_d;
      rr_last_q <= rr_last_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ctrl_credit_selector.sv
// Directed bench with a grant scoreboard for ctrl_credit_selector.
module tb_ctrl_credit_selector;

  localparam int S  = 2;
  localparam int SW = 1;
  localparam int R  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [S-1:0]   s_inc_tdata;
  logic [S-1:0]   s_inc_tready;
  logic [R*SW-1:0] m_selector_tdata;
  logic [R-1:0]   m_selector_tvalid;
  logic [R-1:0]   m_selector_tready;
  logic           credit_return;
  logic           err_credit_ovf;

  int checks = 0;
  int errors = 0;
  int grants = 0;
  int g0;
  int cur_sel = 0;
  bit prev_done = 1'b1;
  int exp_q[$];

  always #5 clk = ~clk;

  ctrl_credit_selector #(
    .S_COUNT(S), .SELECT_WIDTH(SW), .REPLICATED_OUT_NUM(R),
    .CNT_WIDTH(8), .CREDIT_INIT(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_inc_tdata       (s_inc_tdata),
    .s_inc_tready      (s_inc_tready),
    .m_selector_tdata  (m_selector_tdata),
    .m_selector_tvalid (m_selector_tvalid),
    .m_selector_tready (m_selector_tready),
    .credit_return     (credit_return),
    .err_credit_ovf    (err_credit_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; s_inc_tdata = '0; m_selector_tready = '0; credit_return = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  // Bounded drain: scoreboard empty and no valid asserted.
  task automatic drain(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (exp_q.size() == 0 && m_selector_tvalid == '0) break;
      n++;
    end
    chk("drain_timeout", n >= budget, 0);
  endtask

  // Scoreboard: pop expected index at each new broadcast; check every slice every valid cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = 1'b1;
    end else if (m_selector_tvalid != '0) begin
      if (prev_done) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", m_selector_tvalid, 0);
        end else begin
          cur_sel = exp_q.pop_front();
          chk("grant_tvalid", m_selector_tvalid, 3'b111);
        end
        grants++;
      end
      for (int r = 0; r < R; r++)
        chk("tdata_slice", m_selector_tdata[r*SW +: SW], cur_sel);
      prev_done = ((m_selector_tvalid & ~m_selector_tready) == '0);
    end else begin
      prev_done = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; s_inc_tdata = '0; m_selector_tready = '0; credit_return = 1'b0;
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", m_selector_tvalid, 0);
    chk("rst_tdata", m_selector_tdata, 0);
    chk("rst_err", err_credit_ovf, 0);
    chk("rst_inc_tready", s_inc_tready, 2'b11);
    chk("rst_credits", dut.credits_q, 4);

    // Single event on src1: valid exactly at N+2 for one cycle.
    m_selector_tready = 3'b111;
    tick(); s_inc_tdata = 2'b10; exp_q.push_back(1);
    tick(); s_inc_tdata = 2'b00;
    @(negedge clk); chk("lat_n1", m_selector_tvalid, 0);
    tick(); @(negedge clk); chk("lat_n2", m_selector_tvalid, 3'b111);
    tick(); @(negedge clk); chk("one_cycle", m_selector_tvalid, 0);
    chk("cnt1_zero", dut.cnt_q[1], 0);
    chk("credits_3", dut.credits_q, 3);

    // Simultaneous events: 0 then 1 back-to-back, twice.
    do_reset();
    m_selector_tready = 3'b111;
    for (int p = 0; p < 2; p++) begin
      tick(); s_inc_tdata = 2'b11; exp_q.push_back(0); exp_q.push_back(1);
      tick(); s_inc_tdata = 2'b00;
      tick(); @(negedge clk); chk("pair_first", m_selector_tvalid, 3'b111);
      tick(); @(negedge clk); chk("pair_b2b", m_selector_tvalid, 3'b111);
      tick(); @(negedge clk); chk("pair_done", m_selector_tvalid, 0);
    end
    chk("pair_credits", dut.credits_q, 0);

    // Staggered replica acceptance; next grant waits for the last replica.
    do_reset();
    tick(); s_inc_tdata = 2'b01; exp_q.push_back(0);
    tick(); s_inc_tdata = 2'b00;
    tick(); m_selector_tready = 3'b001;
    @(negedge clk); chk("stag_0", m_selector_tvalid, 3'b111);
    tick(); m_selector_tready = 3'b000; s_inc_tdata = 2'b10; exp_q.push_back(1);
    @(negedge clk); chk("stag_1", m_selector_tvalid, 3'b110);
    tick(); s_inc_tdata = 2'b00;
    @(negedge clk); chk("stag_2", m_selector_tvalid, 3'b110);
    tick(); m_selector_tready = 3'b100;
    @(negedge clk); chk("stag_3", m_selector_tvalid, 3'b110);
    tick(); m_selector_tready = 3'b000;
    @(negedge clk); chk("stag_4", m_selector_tvalid, 3'b010);
    tick(); m_selector_tready = 3'b010;
    @(negedge clk); chk("stag_5", m_selector_tvalid, 3'b010);
    tick(); m_selector_tready = 3'b111;
    @(negedge clk); chk("stag_next", m_selector_tvalid, 3'b111);
    drain(20);

    // Credit cap: six events, four grants, then one return frees one more.
    do_reset();
    m_selector_tready = 3'b111;
    g0 = grants;
    for (int k = 0; k < 4; k++) exp_q.push_back(0);
    for (int k = 0; k < 6; k++) begin tick(); s_inc_tdata = 2'b01; end
    tick(); s_inc_tdata = 2'b00;
    cyc(20); @(negedge clk);
    chk("cap_grants", grants - g0, 4);
    chk("cap_cnt", dut.cnt_q[0], 2);
    chk("cap_credits", dut.credits_q, 0);
    tick(); credit_return = 1'b1; exp_q.push_back(0);
    tick(); credit_return = 1'b0;
    cyc(5); @(negedge clk);
    chk("ret_grants", grants - g0, 5);
    chk("ret_cnt", dut.cnt_q[0], 1);

    // Counter saturation with consumers stalled.
    do_reset();
    g0 = grants;
    exp_q.push_back(0);
    tick(); s_inc_tdata = 2'b01;
    cyc(300); s_inc_tdata = 2'b00;
    @(negedge clk);
    chk("sat_cnt", dut.cnt_q[0], 255);
    chk("sat_tready", s_inc_tready, 2'b10);
    for (int k = 0; k < 3; k++) exp_q.push_back(0);
    tick(); m_selector_tready = 3'b111;
    tick(); @(negedge clk);
    chk("sat_rehigh", s_inc_tready[0], 1);
    drain(20);
    chk("sat_grants", grants - g0, 4);
    chk("sat_final_cnt", dut.cnt_q[0], 252);

    // Credit overflow is sticky and leaves the pool at its cap.
    do_reset();
    @(negedge clk); chk("ovf_pre", err_credit_ovf, 0);
    tick(); credit_return = 1'b1;
    tick(); credit_return = 1'b0;
    @(negedge clk);
    chk("ovf_err", err_credit_ovf, 1);
    chk("ovf_credits", dut.credits_q, 4);
    cyc(3); @(negedge clk); chk("ovf_sticky", err_credit_ovf, 1);

    // Reset mid-broadcast: valid drops, counts clear, grant is not reissued.
    do_reset();
    g0 = grants;
    tick(); s_inc_tdata = 2'b10; exp_q.push_back(1);
    tick(); s_inc_tdata = 2'b00;
    tick(); @(negedge clk); chk("mid_bcast", m_selector_tvalid, 3'b111);
    tick(); s_inc_tdata = 2'b01;
    tick(); s_inc_tdata = 2'b00; rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", m_selector_tvalid, 0);
    chk("mid_rst_cnt", dut.cnt_q, 0);
    chk("mid_rst_credits", dut.credits_q, 4);
    cyc(5); @(negedge clk);
    chk("mid_no_reissue", grants - g0, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
